// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial sequencer for an external 1-bit full adder. Two WIDTH-bit operands
// and a carry-in are accepted with a start/ready handshake. The block then feeds
// the adder one bit per clock, LSB first, and keeps the ripple carry in a
// register between cycles. When the last bit has been consumed it registers the
// WIDTH-bit sum, the carry-out and a signed-overflow flag, and pulses done.
//
// Ports
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_start     request, sampled only while o_ready=1
//   i_op_a      operand A, captured on the accepting edge
//   i_op_b      operand B, captured on the accepting edge
//   i_cin       carry-in, captured on the accepting edge
//   o_ready     idle, a start will be accepted
//   o_busy      serial addition in progress
//   o_done      one-cycle pulse, result valid
//   o_sum       registered WIDTH-bit result
//   o_cout      registered carry-out of the MSB
//   o_ovf       registered signed overflow (carry into MSB ^ carry out of MSB)
//   o_fa_a      to full adder a
//   o_fa_b      to full adder b
//   o_fa_cin    to full adder cin
//   i_fa_sum    from full adder sum
//   i_fa_cout   from full adder cout
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic             i_cin,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_fa_a,
  output logic             o_fa_b,
  output logic             o_fa_cin,
  input  logic             i_fa_sum,
  input  logic             i_fa_cout
);

  // The counter must be able to hold WIDTH-1; a 1-bit build still needs one bit.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic [WIDTH-1:0]   r_aSh;
  logic [WIDTH-1:0]   r_bSh;
  logic [WIDTH-1:0]   r_sumSh;
  logic               r_carry;
  logic [CNT_W-1:0]   r_bitCnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_accept;
  logic               w_lastBit;
  logic [WIDTH-1:0]   w_sumNext;

  assign w_accept  = (r_state == IDLE) && i_start;
  assign w_lastBit = (r_bitCnt == LAST_BIT);

  // New adder sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_sumOne
      assign w_sumNext = i_fa_sum;
    end else begin : g_sumWide
      assign w_sumNext = {i_fa_sum, r_sumSh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Handshake flags and the adder drive decode only from registered state, so
  // they stay glitch-free and the adder inputs are quiet outside RUN.
  always_comb begin
    w_nextState = r_state;
    o_ready     = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_fa_a      = 1'b0;
    o_fa_b      = 1'b0;
    o_fa_cin    = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        o_busy   = 1'b1;
        o_fa_a   = r_aSh[0];
        o_fa_b   = r_bSh[0];
        o_fa_cin = r_carry;
        if (w_lastBit) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        o_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // On the final edge r_carry still holds the carry into the MSB, which is
  // what makes carry ^ fa_cout the signed-overflow flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_aSh    <= '0;
      r_bSh    <= '0;
      r_sumSh  <= '0;
      r_carry  <= 1'b0;
      r_bitCnt <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_aSh    <= i_op_a;
      r_bSh    <= i_op_b;
      r_sumSh  <= '0;
      r_carry  <= i_cin;
      r_bitCnt <= '0;
    end else if (r_state == RUN) begin
      r_sumSh  <= w_sumNext;
      r_carry  <= i_fa_cout;
      r_aSh    <= r_aSh >> 1;
      r_bSh    <= r_bSh >> 1;
      r_bitCnt <= r_bitCnt + CNT_W'(1);
      if (w_lastBit) begin
        r_sum  <= w_sumNext;
        r_cout <= i_fa_cout;
        r_ovf  <= r_carry ^ i_fa_cout;
      end
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Testbench for serial_add_ctrl. Two instances are built, WIDTH=8 and WIDTH=1,
// each with a behavioural full adder wired beside it. Stimulus pushes the
// expected result and the cycle on which done must appear into a queue; a
// per-instance monitor pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int W8 = 8;
  localparam int W1 = 1;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          doneCycle;
  } expect_t;

  logic clk = 1'b0;
  int   cycle = 0;
  int   testsRun = 0;
  int   testsFailed = 0;

  expect_t q8[$];
  expect_t q1[$];

  // WIDTH=8 instance signals
  logic          rstN8, start8, cin8, ready8, busy8, done8, cout8, ovf8;
  logic [W8-1:0] opA8, opB8, sum8;
  logic          faA8, faB8, faCin8, faSum8, faCout8;

  // WIDTH=1 instance signals
  logic          rstN1, start1, cin1, ready1, busy1, done1, cout1, ovf1;
  logic [W1-1:0] opA1, opB1, sum1;
  logic          faA1, faB1, faCin1, faSum1, faCout1;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural full adders sitting beside each sequencer.
  assign faSum8  = faA8 ^ faB8 ^ faCin8;
  assign faCout8 = (faA8 & faB8) | (faA8 & faCin8) | (faB8 & faCin8);
  assign faSum1  = faA1 ^ faB1 ^ faCin1;
  assign faCout1 = (faA1 & faB1) | (faA1 & faCin1) | (faB1 & faCin1);

  serial_add_ctrl #(.WIDTH(W8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rstN8), .i_start(start8),
    .i_op_a(opA8), .i_op_b(opB8), .i_cin(cin8),
    .o_ready(ready8), .o_busy(busy8), .o_done(done8),
    .o_sum(sum8), .o_cout(cout8), .o_ovf(ovf8),
    .o_fa_a(faA8), .o_fa_b(faB8), .o_fa_cin(faCin8),
    .i_fa_sum(faSum8), .i_fa_cout(faCout8)
  );

  serial_add_ctrl #(.WIDTH(W1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rstN1), .i_start(start1),
    .i_op_a(opA1), .i_op_b(opB1), .i_cin(cin1),
    .o_ready(ready1), .o_busy(busy1), .o_done(done1),
    .o_sum(sum1), .o_cout(cout1), .o_ovf(ovf1),
    .o_fa_a(faA1), .o_fa_b(faB1), .o_fa_cin(faCin1),
    .i_fa_sum(faSum1), .i_fa_cout(faCout1)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference arithmetic: signed overflow is the carry into the MSB xor carry out.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic c, output logic [31:0] s,
                                output logic co, output logic ov);
    logic [63:0] mask, full, low;
    mask = (64'd1 << w) - 64'd1;
    full = {32'd0, a} + {32'd0, b} + {63'd0, c};
    low  = ({32'd0, a} & (mask >> 1)) + ({32'd0, b} & (mask >> 1)) + {63'd0, c};
    s    = full[31:0] & mask[31:0];
    co   = full[w];
    ov   = low[w-1] ^ full[w];
  endfunction

  always @(negedge clk) begin : mon8
    expect_t e;
    if (rstN8 && done8) begin
      if (q8.size() == 0) begin
        checkOutput("unexpected done W8", {63'd0, done8}, 64'd0);
      end else begin
        e = q8.pop_front();
        checkOutput("sum W8", {56'd0, sum8}, {32'd0, e.sum});
        checkOutput("cout W8", {63'd0, cout8}, {63'd0, e.cout});
        checkOutput("ovf W8", {63'd0, ovf8}, {63'd0, e.ovf});
        checkOutput("done cycle W8", 64'(cycle), 64'(e.doneCycle));
      end
    end
  end

  always @(negedge clk) begin : mon1
    expect_t e;
    if (rstN1 && done1) begin
      if (q1.size() == 0) begin
        checkOutput("unexpected done W1", {63'd0, done1}, 64'd0);
      end else begin
        e = q1.pop_front();
        checkOutput("sum W1", {63'd0, sum1}, {32'd0, e.sum});
        checkOutput("cout W1", {63'd0, cout1}, {63'd0, e.cout});
        checkOutput("ovf W1", {63'd0, ovf1}, {63'd0, e.ovf});
        checkOutput("done cycle W1", 64'(cycle), 64'(e.doneCycle));
      end
    end
  end

  task automatic waitReady8();
    int n = 0;
    while (!ready8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready8) checkOutput("ready timeout W8", {63'd0, ready8}, 64'd1);
  endtask

  task automatic waitReady1();
    int n = 0;
    while (!ready1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready1) checkOutput("ready timeout W1", {63'd0, ready1}, 64'd1);
  endtask

  task automatic waitDrain8();
    int n = 0;
    while (q8.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    checkOutput("drain W8", 64'(q8.size()), 64'd0);
  endtask

  // Issue one directed request with its hand-computed result; returns on the
  // negedge just after the accepting edge with start already dropped.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                               input logic [7:0] expSum, input logic expCout,
                               input logic expOvf);
    expect_t e;
    waitReady8();
    start8 = 1'b1;
    opA8   = a;
    opB8   = b;
    cin8   = c;
    e.sum       = {24'd0, expSum};
    e.cout      = expCout;
    e.ovf       = expOvf;
    e.doneCycle = cycle + 1 + W8;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  initial begin
    logic [7:0]  basicA;
    logic [31:0] rs;
    logic        rco, rov;
    int          prevAccept;
    int          n;
    expect_t     e;

    rstN8 = 1'b0; start8 = 1'b0; opA8 = '0; opB8 = '0; cin8 = 1'b0;
    rstN1 = 1'b0; start1 = 1'b0; opA1 = '0; opB1 = '0; cin1 = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("reset flags W8", {61'd0, ready8, busy8, done8}, 64'b100);
    checkOutput("reset result W8", {54'd0, cout8, ovf8, sum8}, 64'd0);
    checkOutput("reset fa W8", {61'd0, faA8, faB8, faCin8}, 64'd0);
    checkOutput("reset flags W1", {61'd0, ready1, busy1, done1}, 64'b100);
    checkOutput("reset result W1", {61'd0, cout1, ovf1, sum1}, 64'd0);

    rstN8 = 1'b1;
    rstN1 = 1'b1;
    @(negedge clk);

    // Basic add, with busy and the LSB-first adder drive checked each RUN cycle.
    basicA = 8'h2A;
    applyStimulus(8'h2A, 8'h15, 1'b0, 8'h3F, 1'b0, 1'b0);
    for (int i = 0; i < W8; i++) begin
      checkOutput("busy in run W8", {63'd0, busy8}, 64'd1);
      checkOutput("fa_a bit W8", {63'd0, faA8}, {63'd0, basicA[i]});
      @(negedge clk);
    end
    checkOutput("busy/done at done W8", {62'd0, busy8, done8}, 64'b01);
    waitDrain8();

    // Carry chain and signed overflow.
    applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    applyStimulus(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    applyStimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    waitDrain8();

    // Start pulses during RUN and DONE must be ignored.
    applyStimulus(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    start8 = 1'b1;
    opA8   = 8'hAA;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done seen W8", {63'd0, done8}, 64'd1);
    start8 = 1'b1;
    opA8   = 8'hAA;
    @(negedge clk);
    start8 = 1'b0;
    #1;
    checkOutput("ready after done W8", {63'd0, ready8}, 64'd1);
    repeat (15) @(negedge clk);
    checkOutput("no extra op W8", {62'd0, busy8, done8}, 64'd0);
    waitDrain8();

    // Reset in the middle of RUN aborts and clears the previous result.
    applyStimulus(8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rstN8 = 1'b0;
    #1;
    void'(q8.pop_back());
    checkOutput("mid reset flags W8", {61'd0, ready8, busy8, done8}, 64'b100);
    checkOutput("mid reset result W8", {54'd0, cout8, ovf8, sum8}, 64'd0);
    checkOutput("mid reset fa W8", {61'd0, faA8, faB8, faCin8}, 64'd0);
    repeat (2) @(negedge clk);
    rstN8 = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
    waitDrain8();

    // Back-to-back random operations, WIDTH=8.
    prevAccept = -1;
    start8 = 1'b1;
    for (int k = 0; k < 200; k++) begin
      waitReady8();
      opA8 = 8'($urandom);
      opB8 = 8'($urandom);
      cin8 = 1'($urandom_range(0, 1));
      model(W8, {24'd0, opA8}, {24'd0, opB8}, cin8, rs, rco, rov);
      e.sum = rs; e.cout = rco; e.ovf = rov; e.doneCycle = cycle + 1 + W8;
      q8.push_back(e);
      if (prevAccept >= 0) checkOutput("accept spacing W8", 64'(cycle + 1 - prevAccept), 64'(W8 + 2));
      prevAccept = cycle + 1;
      @(negedge clk);
    end
    start8 = 1'b0;
    waitDrain8();

    // Back-to-back random operations, WIDTH=1.
    prevAccept = -1;
    start1 = 1'b1;
    for (int k = 0; k < 200; k++) begin
      waitReady1();
      opA1 = 1'($urandom_range(0, 1));
      opB1 = 1'($urandom_range(0, 1));
      cin1 = 1'($urandom_range(0, 1));
      model(W1, {31'd0, opA1}, {31'd0, opB1}, cin1, rs, rco, rov);
      e.sum = rs; e.cout = rco; e.ovf = rov; e.doneCycle = cycle + 1 + W1;
      q1.push_back(e);
      if (prevAccept >= 0) checkOutput("accept spacing W1", 64'(cycle + 1 - prevAccept), 64'(W1 + 2));
      prevAccept = cycle + 1;
      @(negedge clk);
    end
    start1 = 1'b0;
    n = 0;
    while (q1.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #1;
    checkOutput("drain W1", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
